// File: rtl/quat_normalizer.sv
// Quaternion normaliser: sum of squares, power-of-two seed for 1/sqrt, iterated external
// Newton-Raphson refinement over a start/done handshake, then per-component scaling.
module quat_normalizer #(
    parameter int unsigned INT_WIDTH   = 12,
    parameter int unsigned FRACT_WIDTH = 4,
    parameter int unsigned NR_ITERS    = 2,
    localparam int unsigned WORD       = INT_WIDTH + FRACT_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            done,
    input  logic [WORD-1:0] q0,
    input  logic [WORD-1:0] q1,
    input  logic [WORD-1:0] q2,
    input  logic [WORD-1:0] q3,
    output logic [WORD-1:0] n0,
    output logic [WORD-1:0] n1,
    output logic [WORD-1:0] n2,
    output logic [WORD-1:0] n3,
    output logic            zero_norm,
    output logic            isqrt_start,
    input  logic            isqrt_done,
    output logic [WORD-1:0] isqrt_x_half,
    output logic [WORD-1:0] isqrt_y0,
    input  logic [WORD-1:0] isqrt_y
);

    localparam int unsigned SW   = 2 * WORD + 2;
    localparam int unsigned PW   = 2 * WORD + 1;
    localparam int unsigned CntW = $clog2(NR_ITERS + 1);

    localparam logic [SW-1:0]        SHalf   = SW'(1) << (FRACT_WIDTH - 1);
    localparam logic signed [PW-1:0] PHalf   = PW'(1) << (FRACT_WIDTH - 1);
    localparam logic signed [PW-1:0] NMax    = {{(WORD + 2){1'b0}}, {(WORD - 1){1'b1}}};
    localparam logic signed [PW-1:0] NMin    = {{(WORD + 2){1'b1}}, {(WORD - 1){1'b0}}};
    localparam logic [CntW-1:0]      CntLast = CntW'(NR_ITERS);

    typedef enum logic [2:0] {
        StIdle,
        StSquare,
        StSeed,
        StNrReq,
        StNrRel,
        StScale,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic signed [WORD-1:0] q_q [4];
    logic signed [WORD-1:0] q_d [4];
    logic [WORD-1:0]        n_q [4];
    logic [WORD-1:0]        n_d [4];
    logic [WORD-1:0]        s_q, s_d;
    logic [WORD-1:0]        x_half_q, x_half_d;
    logic [WORD-1:0]        y0_q, y0_d;
    logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                   done_q, done_d;
    logic                   isqrt_start_q, isqrt_start_d;
    logic                   zero_norm_q, zero_norm_d;

    // Sum of squares, rounded back to the word's fraction and saturated.
    logic signed [2*WORD-1:0] sq [4];
    logic [SW-1:0]            s_raw, s_rnd, s_shr;
    logic [WORD-1:0]          s_sat;

    always_comb begin
        s_raw = '0;
        for (int i = 0; i < 4; i++) begin
            sq[i] = (2*WORD)'(q_q[i]) * (2*WORD)'(q_q[i]);
            s_raw = s_raw + {2'b00, sq[i]};
        end
        s_rnd = s_raw + SHalf;
        s_shr = s_rnd >> FRACT_WIDTH;
        s_sat = (|s_shr[SW-1:WORD]) ? '1 : s_shr[WORD-1:0];
    end

    // Seed 2^-floor(e/2), where e is the unbiased exponent of s.
    int              lead, e, k, shift;
    logic [WORD-1:0] seed;

    always_comb begin
        lead = 0;
        for (int i = 0; i < int'(WORD); i++) begin
            if (s_q[i]) lead = i;
        end
        e     = lead - int'(FRACT_WIDTH);
        k     = e >>> 1;
        shift = int'(FRACT_WIDTH) - k;
        seed  = (shift < 0) ? WORD'(1) : (WORD'(1) << shift);
    end

    logic signed [PW-1:0] prod     [4];
    logic signed [PW-1:0] prod_rnd [4];
    logic signed [PW-1:0] prod_shr [4];
    logic [WORD-1:0]      scaled   [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            prod[i]     = PW'(q_q[i]) * PW'($signed({1'b0, y0_q}));
            prod_rnd[i] = prod[i] + PHalf;
            prod_shr[i] = prod_rnd[i] >>> FRACT_WIDTH;
            if (prod_shr[i] > NMax) begin
                scaled[i] = {1'b0, {(WORD - 1){1'b1}}};
            end else if (prod_shr[i] < NMin) begin
                scaled[i] = {1'b1, {(WORD - 1){1'b0}}};
            end else begin
                scaled[i] = prod_shr[i][WORD-1:0];
            end
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StSquare;
            StSquare: state_d = (s_sat == '0) ? StDone : StSeed;
            StSeed:   state_d = StNrReq;
            StNrReq:  if (isqrt_done) state_d = StNrRel;
            StNrRel: begin
                if (!isqrt_done) state_d = (cnt_inc == CntLast) ? StScale : StNrReq;
            end
            StScale:  state_d = StDone;
            StDone:   if (!start) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        q_d           = q_q;
        n_d           = n_q;
        s_d           = s_q;
        x_half_d      = x_half_q;
        y0_d          = y0_q;
        cnt_d         = cnt_q;
        zero_norm_d   = zero_norm_q;
        // done trails the state by one edge, so it stays up one cycle after leaving StDone.
        done_d        = (state_q == StDone);
        isqrt_start_d = (state_d == StNrReq);
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    q_d[0] = q0;
                    q_d[1] = q1;
                    q_d[2] = q2;
                    q_d[3] = q3;
                end
            end
            StSquare: begin
                s_d = s_sat;
                if (s_sat == '0) begin
                    for (int i = 0; i < 4; i++) n_d[i] = '0;
                    zero_norm_d = 1'b1;
                end else begin
                    zero_norm_d = 1'b0;
                end
            end
            StSeed: begin
                x_half_d = s_q >> 1;
                y0_d     = seed;
                cnt_d    = '0;
            end
            StNrReq:  if (isqrt_done) y0_d = isqrt_y;
            StNrRel:  if (!isqrt_done) cnt_d = cnt_inc;
            StScale:  n_d = scaled;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                q_q[i] <= '0;
                n_q[i] <= '0;
            end
            s_q           <= '0;
            x_half_q      <= '0;
            y0_q          <= '0;
            cnt_q         <= '0;
            done_q        <= 1'b0;
            isqrt_start_q <= 1'b0;
            zero_norm_q   <= 1'b0;
        end else begin
            q_q           <= q_d;
            n_q           <= n_d;
            s_q           <= s_d;
            x_half_q      <= x_half_d;
            y0_q          <= y0_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            isqrt_start_q <= isqrt_start_d;
            zero_norm_q   <= zero_norm_d;
        end
    end

    assign done         = done_q;
    assign n0           = n_q[0];
    assign n1           = n_q[1];
    assign n2           = n_q[2];
    assign n3           = n_q[3];
    assign zero_norm    = zero_norm_q;
    assign isqrt_start  = isqrt_start_q;
    assign isqrt_x_half = x_half_q;
    assign isqrt_y0     = y0_q;

endmodule

// File: tb/tb_quat_normalizer.sv
// Bench for quat_normalizer: directed vector table, hand-written corner sequences and
// randomized quaternions checked against an arithmetic reference, with a start/done isqrt core.
module tb_quat_normalizer;

    localparam int W  = 16;
    localparam int F  = 4;
    localparam int NR = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] q0 = '0, q1 = '0, q2 = '0, q3 = '0;
    logic         done;
    logic [W-1:0] n0, n1, n2, n3;
    logic         zero_norm;
    logic         isqrt_start;
    logic         isqrt_done = 1'b0;
    logic [W-1:0] isqrt_x_half, isqrt_y0;
    logic [W-1:0] isqrt_y = '0;

    int n_pass = 0, n_total = 0;
    int rise_total = 0, stab_err = 0, reassert_err = 0;
    int xh_log[$];
    int y0_log[$];
    logic         prev_start = 1'b0;
    logic [W-1:0] prev_xh = '0, prev_y0 = '0;

    quat_normalizer #(
        .INT_WIDTH  (12),
        .FRACT_WIDTH(F),
        .NR_ITERS   (NR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .done        (done),
        .q0          (q0),
        .q1          (q1),
        .q2          (q2),
        .q3          (q3),
        .n0          (n0),
        .n1          (n1),
        .n2          (n2),
        .n3          (n3),
        .zero_norm   (zero_norm),
        .isqrt_start (isqrt_start),
        .isqrt_done  (isqrt_done),
        .isqrt_x_half(isqrt_x_half),
        .isqrt_y0    (isqrt_y0),
        .isqrt_y     (isqrt_y)
    );

    always #5 clk = ~clk;

    // One Newton-Raphson step y*(1.5 - x_half*y^2) in Q.F, rounded to nearest.
    function automatic longint nr_step(input longint xh, input longint y);
        longint t;
        t = y * ((longint'(3) << (3 * F - 1)) - xh * y * y);
        t = (t + (longint'(1) << (3 * F - 1))) >>> (3 * F);
        if (t < 0) t = 0;
        if (t > 65535) t = 65535;
        return t;
    endfunction

    // Refinement core: idle, compute (random latency), hold done, release.
    typedef enum logic [1:0] {CIdle, CCalc, CHold, CRel} core_e;
    core_e        cst = CIdle;
    int           clat = 0;
    logic [W-1:0] cy = '0;

    always @(posedge clk) begin
        if (rst) begin
            cst        <= CIdle;
            isqrt_done <= 1'b0;
        end else begin
            case (cst)
                CIdle: if (isqrt_start) begin
                    cy   <= 16'(nr_step(longint'(isqrt_x_half), longint'(isqrt_y0)));
                    clat <= int'($urandom_range(0, 2));
                    cst  <= CCalc;
                end
                CCalc: begin
                    if (!isqrt_start) cst <= CIdle;
                    else if (clat == 0) begin
                        isqrt_done <= 1'b1;
                        isqrt_y    <= cy;
                        cst        <= CHold;
                    end else clat <= clat - 1;
                end
                CHold: if (!isqrt_start) begin
                    isqrt_done <= 1'b0;
                    cst        <= CRel;
                end
                default: cst <= CIdle;
            endcase
        end
    end

    always @(negedge clk) begin
        if (isqrt_start && !prev_start) begin
            rise_total <= rise_total + 1;
            xh_log.push_back(int'(isqrt_x_half));
            y0_log.push_back(int'(isqrt_y0));
            if (isqrt_done) reassert_err <= reassert_err + 1;
        end
        if (isqrt_start && prev_start && (isqrt_x_half != prev_xh || isqrt_y0 != prev_y0))
            stab_err <= stab_err + 1;
        prev_start <= isqrt_start;
        prev_xh    <= isqrt_x_half;
        prev_y0    <= isqrt_y0;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic logic [3:0][W-1:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic void ref_model(input logic [3:0][W-1:0] qv,
                                      output logic [3:0][W-1:0] nv, output bit zn);
        longint s_raw, s, y, xh, p, qi;
        int     lo, e, kk, sh;
        s_raw = 0;
        for (int i = 0; i < 4; i++) begin
            qi    = longint'($signed(qv[i]));
            s_raw = s_raw + qi * qi;
        end
        s = (s_raw + (1 << (F - 1))) / (1 << F);
        if (s > 65535) s = 65535;
        nv = '0;
        zn = (s == 0);
        if (zn) return;
        lo = 0;
        while ((longint'(1) << (lo + 1)) <= s) lo++;
        e  = lo - F;
        kk = (e >= 0) ? e / 2 : -((1 - e) / 2);
        sh = F - kk;
        y  = (sh < 0) ? 1 : (longint'(1) << sh);
        xh = s / 2;
        for (int it = 0; it < NR; it++) y = nr_step(xh, y);
        for (int i = 0; i < 4; i++) begin
            p = (longint'($signed(qv[i])) * y + (1 << (F - 1))) >>> F;
            if (p > 32767) p = 32767;
            if (p < -32768) p = -32768;
            nv[i] = 16'(p);
        end
    endfunction

    task automatic do_op(input logic [3:0][W-1:0] qv, output int lat);
        @(negedge clk);
        q0 = qv[0]; q1 = qv[1]; q2 = qv[2]; q3 = qv[3];
        start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                q0 = 16'($urandom); q1 = 16'($urandom); q2 = 16'($urandom); q3 = 16'($urandom);
            end
        end while (!done && lat < 400);
        chk("op_completes", longint'(done), 1);
    endtask

    task automatic release_op();
        int k = 0;
        start = 1'b0;
        while (done && k < 8) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("done_release", longint'(done), 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0][W-1:0] q;
        logic [3:0][W-1:0] n;
        bit                zn;
        int                xh;
        int                seed;
        int                y1;
    } vec_t;

    vec_t              vecs[6];
    logic [3:0][W-1:0] nd, nexp, qv;
    bit                zexp;
    int                lat, r0, wt;

    initial begin
        vecs[0] = '{q: pk(16, 0, 0, 0),  n: pk(16, 0, 0, 0),  zn: 0, xh: 8,   seed: 16, y1: 16};
        vecs[1] = '{q: pk(32, 0, 0, 0),  n: pk(16, 0, 0, 0),  zn: 0, xh: 32,  seed: 8,  y1: 8};
        vecs[2] = '{q: pk(48, 64, 0, 0), n: pk(9, 12, 0, 0),  zn: 0, xh: 200, seed: 4,  y1: 3};
        vecs[3] = '{q: pk(-32, 0, 0, 0), n: pk(-16, 0, 0, 0), zn: 0, xh: 32,  seed: 8,  y1: 8};
        vecs[4] = '{q: pk(0, 0, 0, 0),   n: pk(0, 0, 0, 0),   zn: 1, xh: 0,   seed: 0,  y1: 0};
        vecs[5] = '{q: pk(0, 0, -16, 0), n: pk(0, 0, -16, 0), zn: 0, xh: 8,   seed: 16, y1: 16};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", longint'(done), 0);
        chk("rst_isqrt_start", longint'(isqrt_start), 0);
        chk("rst_n", longint'({n3, n2, n1, n0}), 0);
        chk("rst_zero_norm", longint'(zero_norm), 0);
        chk("rst_x_half", longint'(isqrt_x_half), 0);
        chk("rst_y0", longint'(isqrt_y0), 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            r0 = rise_total;
            do_op(vecs[v].q, lat);
            nd = {n3, n2, n1, n0};
            for (int i = 0; i < 4; i++)
                chk($sformatf("vec%0d_n%0d", v, i), longint'(nd[i]), longint'(vecs[v].n[i]));
            chk($sformatf("vec%0d_zero_norm", v), longint'(zero_norm), longint'(vecs[v].zn));
            if (vecs[v].zn) begin
                chk($sformatf("vec%0d_isqrt_reqs", v), rise_total - r0, 0);
                chk($sformatf("vec%0d_latency", v), lat, 3);
            end else begin
                chk($sformatf("vec%0d_isqrt_reqs", v), rise_total - r0, NR);
                if (rise_total >= r0 + 2) begin
                    chk($sformatf("vec%0d_x_half", v), xh_log[r0], vecs[v].xh);
                    chk($sformatf("vec%0d_seed", v), y0_log[r0], vecs[v].seed);
                    chk($sformatf("vec%0d_y_pass1", v), y0_log[r0 + 1], vecs[v].y1);
                end
            end
            release_op();
        end

        // Start held high after done: block parks in DONE with no extra request.
        r0 = rise_total;
        do_op(pk(16, 0, 0, 0), lat);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("hold_done_high", longint'(done), 1);
        chk("hold_isqrt_reqs", rise_total - r0, NR);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("hold_done_after_1_edge", longint'(done), 1);
        @(posedge clk);
        @(negedge clk);
        chk("hold_done_after_2_edges", longint'(done), 0);

        // Start dropped right after accept: operation completes, done pulses one cycle.
        q0 = 16'd48; q1 = 16'd64; q2 = '0; q3 = '0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wt = 0;
        while (!done && wt < 400) begin
            @(posedge clk);
            @(negedge clk);
            wt++;
        end
        chk("early_drop_done", longint'(done), 1);
        chk("early_drop_n0", longint'(n0), 9);
        chk("early_drop_n1", longint'(n1), 12);
        @(posedge clk);
        @(negedge clk);
        chk("early_drop_pulse_1cyc", longint'(done), 0);
        @(posedge clk);
        @(negedge clk);

        // Reset while the isqrt request is outstanding.
        q0 = 16'd48; q1 = 16'd64; q2 = '0; q3 = '0;
        start = 1'b1;
        wt = 0;
        while (!isqrt_start && wt < 50) begin
            @(posedge clk);
            @(negedge clk);
            wt++;
        end
        chk("mid_rst_reached_req", longint'(isqrt_start), 1);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_isqrt_start", longint'(isqrt_start), 0);
        chk("mid_rst_done", longint'(done), 0);
        chk("mid_rst_n", longint'({n3, n2, n1, n0}), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        r0 = rise_total;
        do_op(pk(8, 8, 8, 8), lat);
        chk("post_rst_n", longint'({n3, n2, n1, n0}), longint'(pk(8, 8, 8, 8)));
        chk("post_rst_reqs", rise_total - r0, NR);
        release_op();

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: for (int i = 0; i < 4; i++) qv[i] = 16'($urandom);
                1, 2: for (int i = 0; i < 4; i++) qv[i] = 16'($urandom_range(0, 511) - 256);
                default: begin
                    qv = '0;
                    qv[$urandom_range(0, 3)] = 16'($urandom_range(0, 3));
                end
            endcase
            ref_model(qv, nexp, zexp);
            r0 = rise_total;
            do_op(qv, lat);
            nd = {n3, n2, n1, n0};
            for (int i = 0; i < 4; i++)
                chk($sformatf("rnd%0d_n%0d", it, i), longint'(nd[i]), longint'(nexp[i]));
            chk($sformatf("rnd%0d_zero_norm", it), longint'(zero_norm), longint'(zexp));
            chk($sformatf("rnd%0d_isqrt_reqs", it), rise_total - r0, zexp ? 0 : NR);
            release_op();
        end

        chk("isqrt_operands_stable", stab_err, 0);
        chk("isqrt_no_reassert_before_release", reassert_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/quat_normalizer.md
# quat_normalizer

Sequencer that normalises a fixed-point quaternion for the Madgwick filter: it sums the squared components, forms a seed estimate of 1/sqrt(|q|²), and acts as the initiator on the start/done handshake of the Newton-Raphson inverse-square-root refinement core. It iterates that core, then scales each component by the result. It sits between the filter's quaternion-integration stage and the state register.

## Interface
- INT_WIDTH, 12, integer bits of every word
- FRACT_WIDTH, 4, fractional bits of every word (WORD = INT_WIDTH+FRACT_WIDTH)
- NR_ITERS, 2, refinement-core passes per normalisation (≥1)

- clk  in  1  clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level request from the filter
- done  out  1  result valid; held until start is low
- q0..q3  in  WORD each  signed two's-complement Q(INT.FRACT) components, sampled on accept
- n0..n3  out  WORD each  signed normalised components
- zero_norm  out  1  sum of squares was 0 for the last result
- isqrt_start  out  1  request to the refinement core
- isqrt_done  in  1  completion from the refinement core
- isqrt_x_half  out  WORD  unsigned s/2
- isqrt_y0  out  WORD  unsigned current estimate
- isqrt_y  in  WORD  unsigned refined estimate

## Operation
- States: IDLE, SQUARE, SEED, NR_REQ, NR_REL, SCALE, DONE.
- IDLE: done=0. If start=1, latch q0..q3 and go to SQUARE.
- SQUARE (1 cycle): compute s_raw = Σ qi² at full width (2·WORD+2 bits, 2·FRACT frac bits). Form s = (s_raw + 2^(FRACT-1)) >> FRACT, saturated to unsigned WORD max. If s=0, set n0..n3=0 and zero_norm=1, then go to DONE. Otherwise set zero_norm=0 and go to SEED.
- SEED (1 cycle):
  - e = (leading-one index of s) − FRACT_WIDTH; k = floor(e/2), using arithmetic floor for negative e.
  - y0 = 1 << (FRACT_WIDTH − k). If the shift is negative, y0 = 1 LSB.
  - Set x_half = s >> 1 (truncating). Iteration counter = 0. Go to NR_REQ.
- NR_REQ: isqrt_start=1. When isqrt_done=1, capture isqrt_y as the next y0, drop isqrt_start, and go to NR_REL.
- NR_REL: isqrt_start=0. Wait for isqrt_done=0. Then increment the counter. If counter = NR_ITERS go to SCALE, else go to NR_REQ.
- SCALE (1 cycle): ni = round(qi · {0,y0}) >> FRACT, with round = +2^(FRACT-1) on the signed product. Saturate to the signed WORD range. Go to DONE.
- DONE: done=1. When start=0, go to IDLE; done falls on the following edge.
- isqrt_x_half and isqrt_y0 are registered and stable whenever isqrt_start=1.
- Changes on q while the block is busy are ignored.

## Timing
- Reset values: done=0, isqrt_start=0, n0..n3=0, zero_norm=0, isqrt_x_half=0, isqrt_y0=0; state=IDLE.
- Reset asserted in any state aborts the operation on the next edge and drives isqrt_start low. The refinement core sees start fall and returns to its idle state.
- Latency from start sampled in IDLE to done=1:
  - Base: 3 cycles (SQUARE, SEED, SCALE) + 1 cycle to enter DONE.
  - Plus, per pass, the core's start→done latency + 1 (NR_REQ exit) + the core's done-fall latency.
  - Zero-norm path: done=1 two cycles after accept.
- isqrt_start never re-asserts until isqrt_done has been seen low. There is no back-to-back request without release.
- start held high after done: the block stays in DONE. A new operation needs start low for at least 1 cycle.
- start dropped before DONE: the operation still completes. The block then passes straight from DONE to IDLE, and done is high for 1 cycle.
- Outputs n0..n3 and zero_norm hold their values until the next SCALE, zero-norm SQUARE, or reset.

## Test plan
All values are for the defaults (Q12.4); refinement-core model is the 4-state start/done core.
- q=(16,0,0,0) (1.0) -> isqrt_x_half=8, isqrt_y0=16, final y=16; n=(16,0,0,0), zero_norm=0.
- q=(32,0,0,0) (2.0) -> seed y0=8 (0.5); n0=16.
- q=(48,64,0,0) (3,4) -> s=400, x_half=200, seed 4, y=3 on both passes; n=(9,12,0,0). q=(−32,0,0,0) -> n0=0xFFF0.
- q=(0,0,0,0) -> done 2 cycles after accept; n all 0, zero_norm=1; isqrt_start never asserted.
- Assert rst during NR_REQ -> next edge: isqrt_start=0, done=0, n=0, state IDLE. Then start with q=(8,8,8,8) -> n=(8,8,8,8).
- Hold start high after done -> done stays 1 and no second isqrt request occurs. Drop start -> done=0 after 2 edges. Count exactly NR_ITERS isqrt_start rising edges per operation.
